// File: rtl/mat_operand_fetch.sv
// mat_operand_fetch: fetches strided matrix rows over a 64-bit RAM port into LANES x ELEM_W row vectors.
// Optional OPFETCH_STALL_CNT_EN adds a per-job backpressure cycle counter output.
module mat_operand_fetch #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [63:0]               base,
    input  logic [31:0]               rows,
    input  logic [4:0]                cols,
    input  logic [63:0]               stride,
    output logic                      mem_ren,
    output logic [63:0]               mem_raddr,
    input  logic [63:0]               mem_rdata,
    output logic                      vec_valid,
    input  logic                      vec_ready,
    output logic [LANES*ELEM_W-1:0]   vec_data,
    output logic                      vec_last,
    output logic                      busy,
    output logic                      done
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);
    localparam int LB = $clog2(LANES);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
    state_t state, nxt;
    logic [63:0] row_addr, stride_q;
    logic [31:0] rows_q, row_idx;
    logic [4:0] cols_q, cols_clamp;
    logic [3:0] n_rd, iss, rcv;
    logic [5:0] lo_lane, hi_lane;
    logic [LANES*ELEM_W-1:0] vec_q;
    logic rd_pend, hs, last_row, accept, empty;
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^row_addr[1:0];
    assign cols_clamp = cols > 5'(LANES) ? 5'(LANES) : cols;
    assign accept = state == IDLE && start;
    assign empty = rows == 32'd0 || cols == 5'd0;
    assign n_rd = 4'((5'(row_addr[2]) + cols_q + 5'd1) >> 1);
    assign mem_ren = state == FETCH && iss < n_rd;
    assign mem_raddr = mem_ren ? {row_addr[63:3], 3'b000} + {57'd0, iss, 3'b000} : 64'd0;
    assign vec_valid = state == HOLD;
    assign hs = vec_valid && vec_ready;
    assign last_row = row_idx == rows_q - 32'd1;
    assign vec_last = vec_valid && last_row;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign vec_data = vec_q;
    // Stream position of each half, shifted down by one when the row starts on an odd word.
    assign lo_lane = {1'b0, rcv, 1'b0} - {5'd0, row_addr[2]};
    assign hi_lane = {1'b0, rcv, 1'b1} - {5'd0, row_addr[2]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (empty ? DONE : FETCH) : IDLE;
            FETCH:   nxt = (rd_pend && rcv == n_rd - 4'd1) ? HOLD : FETCH;
            HOLD:    nxt = hs ? (last_row ? DONE : FETCH) : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_addr <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            row_idx  <= '0;
            iss      <= '0;
            rcv      <= '0;
            rd_pend  <= 1'b0;
            vec_q    <= '0;
        end else begin
            rd_pend <= mem_ren;
            if (accept) begin
                row_addr <= base;
                stride_q <= stride;
                rows_q   <= rows;
                cols_q   <= cols_clamp;
                row_idx  <= '0;
                iss      <= '0;
                rcv      <= '0;
                vec_q    <= '0;
            end else if (hs) begin
                row_addr <= row_addr + stride_q;
                row_idx  <= row_idx + 32'd1;
                iss      <= '0;
                rcv      <= '0;
                vec_q    <= '0;
            end else begin
                if (mem_ren) iss <= iss + 4'd1;
                if (rd_pend) begin
                    rcv <= rcv + 4'd1;
                    if (lo_lane < {1'b0, cols_q}) vec_q[lo_lane[LB-1:0]*ELEM_W +: ELEM_W] <= mem_rdata[31:0];
                    if (hi_lane < {1'b0, cols_q}) vec_q[hi_lane[LB-1:0]*ELEM_W +: ELEM_W] <= mem_rdata[63:32];
                end
            end
        end
    end
`ifdef OPFETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (accept) stall_cnt <= '0;
        else if (vec_valid && !vec_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mat_operand_fetch.sv
// tb_mat_operand_fetch: directed bench for mat_operand_fetch with a synchronous RAM model.
module tb_mat_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [63:0] base = '0;
    logic [31:0] rows = '0;
    logic [4:0] cols = '0;
    logic [63:0] stride = '0;
    logic mem_ren;
    logic [63:0] mem_raddr;
    logic [63:0] mem_rdata = '0;
    logic vec_valid;
    logic vec_ready = 1'b1;
    logic [511:0] vec_data;
    logic vec_last, busy, done;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    int tests = 0;
    int fails = 0;

    mat_operand_fetch dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .rows(rows), .cols(cols), .stride(stride),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_last(vec_last),
        .busy(busy), .done(done)
`ifdef OPFETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [511:0] exp_vec(input logic [63:0] a, input int nc);
        logic [511:0] v = '0;
        for (int k = 0; k < 16; k++)
            if (k < nc) v[k*32 +: 32] = word(a + 64'(4*k));
        return v;
    endfunction

    always @(posedge clk)
        if (mem_ren) mem_rdata <= {word(mem_raddr + 64'd4), word(mem_raddr)};

    task automatic start_job(input logic [63:0] b, input logic [31:0] r, input logic [4:0] c, input logic [63:0] s);
        @(posedge clk); #1;
        base = b; rows = r; cols = c; stride = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({mem_ren, mem_raddr, vec_valid, vec_data, vec_last, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got ren=%b addr=%h valid=%b last=%b busy=%b done=%b exp all 0",
                     mem_ren, mem_raddr, vec_valid, vec_last, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned;
        logic [3:0] e;
        vec_ready = 1'b1;
        start_job(64'h8000_0000, 32'd1, 5'd16, 64'd0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            e = {cyc <= 8, cyc == 10, cyc == 11, cyc <= 11};
            tests++;
            if ({mem_ren, vec_valid, done, busy} !== e) begin
                fails++;
                $display("FAIL aligned_ctl cyc=%0d got ren/valid/done/busy=%b exp=%b", cyc, {mem_ren, vec_valid, done, busy}, e);
            end
            if (cyc <= 8) begin
                tests++;
                if (mem_raddr !== 64'h8000_0000 + 64'(8*(cyc-1))) begin
                    fails++;
                    $display("FAIL aligned_addr cyc=%0d got=%h exp=%h", cyc, mem_raddr, 64'h8000_0000 + 64'(8*(cyc-1)));
                end
            end
            if (cyc == 10) begin
                tests++;
                if (vec_data !== exp_vec(64'h8000_0000, 16) || vec_last !== 1'b1) begin
                    fails++;
                    $display("FAIL aligned_data last=%b got=%h exp=%h", vec_last, vec_data, exp_vec(64'h8000_0000, 16));
                end
            end
        end
    endtask

    task automatic test_misaligned;
        logic [2:0] e;
        start_job(64'h8000_0004, 32'd1, 5'd3, 64'd0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            e = {cyc <= 2, cyc == 4, cyc == 5};
            tests++;
            if ({mem_ren, vec_valid, done} !== e) begin
                fails++;
                $display("FAIL misaligned_ctl cyc=%0d got=%b exp=%b", cyc, {mem_ren, vec_valid, done}, e);
            end
            if (cyc <= 2) begin
                tests++;
                if (mem_raddr !== 64'h8000_0000 + 64'(8*(cyc-1))) begin
                    fails++;
                    $display("FAIL misaligned_addr cyc=%0d got=%h exp=%h", cyc, mem_raddr, 64'h8000_0000 + 64'(8*(cyc-1)));
                end
            end
            if (cyc == 4) begin
                tests++;
                if (vec_data !== exp_vec(64'h8000_0004, 3)) begin
                    fails++;
                    $display("FAIL misaligned_data got=%h exp=%h", vec_data, exp_vec(64'h8000_0004, 3));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] b = 64'h8000_1000;
        logic [511:0] held = '0;
        int row = 0, stall = 0, starts = 0;
        bit prev_ren = 0, fin = 0;
        vec_ready = 1'b1;
        start_job(b, 32'd4, 5'd8, 64'h40);
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            if (row == 4) begin
                tests++;
                if (done !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_done got=%b exp=1", done);
                end
                fin = 1;
            end else begin
                if (mem_ren && !prev_ren) begin
                    starts++;
                    tests++;
                    if (mem_raddr !== b + 64'(row) * 64'h40) begin
                        fails++;
                        $display("FAIL bp_row_addr row=%0d got=%h exp=%h", row, mem_raddr, b + 64'(row) * 64'h40);
                    end
                end
                prev_ren = mem_ren;
                if (vec_valid) begin
                    tests++;
                    if (vec_data !== exp_vec(b + 64'(row) * 64'h40, 8) || vec_last !== (row == 3)) begin
                        fails++;
                        $display("FAIL bp_data row=%0d last=%b got=%h exp=%h", row, vec_last, vec_data, exp_vec(b + 64'(row) * 64'h40, 8));
                    end
                    if (row == 1 && stall < 5) begin
                        if (stall > 0) begin
                            tests++;
                            if (vec_data !== held) begin
                                fails++;
                                $display("FAIL bp_stable got=%h exp=%h", vec_data, held);
                            end
                        end
                        held = vec_data;
                        stall++;
                        vec_ready = 1'b0;
                    end else begin
                        vec_ready = 1'b1;
                        row++;
                    end
                end
            end
        end
        vec_ready = 1'b1;
        tests++;
        if (!fin || starts != 4) begin
            fails++;
            $display("FAIL bp_complete got finished=%0d rows_started=%0d exp finished=1 rows_started=4", fin, starts);
        end
`ifdef OPFETCH_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd5) begin
            fails++;
            $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt);
        end
`endif
    endtask

    task automatic test_empty;
        start_job(64'h8000_0000, 32'd0, 5'd8, 64'h40);
        @(negedge clk);
        tests++;
        if ({done, mem_ren, busy} !== 3'b101) begin
            fails++;
            $display("FAIL empty_rows_c1 got done/ren/busy=%b exp=101", {done, mem_ren, busy});
        end
        @(negedge clk);
        tests++;
        if ({done, mem_ren, busy} !== 3'b000) begin
            fails++;
            $display("FAIL empty_rows_c2 got done/ren/busy=%b exp=000", {done, mem_ren, busy});
        end
        start_job(64'h8000_0000, 32'd3, 5'd0, 64'h40);
        @(negedge clk);
        tests++;
        if ({done, mem_ren, busy} !== 3'b101) begin
            fails++;
            $display("FAIL empty_cols_c1 got done/ren/busy=%b exp=101", {done, mem_ren, busy});
        end
    endtask

    task automatic test_clamp;
        logic [2:0] e;
        start_job(64'h8000_0200, 32'd1, 5'd20, 64'd0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            e = {cyc <= 8, cyc == 10, cyc == 11};
            tests++;
            if ({mem_ren, vec_valid, done} !== e) begin
                fails++;
                $display("FAIL clamp_ctl cyc=%0d got=%b exp=%b", cyc, {mem_ren, vec_valid, done}, e);
            end
            if (cyc == 10) begin
                tests++;
                if (vec_data !== exp_vec(64'h8000_0200, 16)) begin
                    fails++;
                    $display("FAIL clamp_data got=%h exp=%h", vec_data, exp_vec(64'h8000_0200, 16));
                end
            end
        end
    endtask

    task automatic test_start_busy;
        logic [63:0] b = 64'h8000_2000;
        logic [2:0] e;
        logic [63:0] ea;
        start_job(b, 32'd2, 5'd4, 64'h40);
        base = 64'h9000_0000; rows = 32'd7; cols = 5'd1; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            e = {cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6, cyc == 4 || cyc == 8, cyc == 9};
            tests++;
            if ({mem_ren, vec_valid, done} !== e) begin
                fails++;
                $display("FAIL busy_start_ctl cyc=%0d got=%b exp=%b", cyc, {mem_ren, vec_valid, done}, e);
            end
            if (e[2]) begin
                ea = cyc >= 5 ? b + 64'h40 + 64'(8*(cyc-5)) : b + 64'(8*(cyc-1));
                tests++;
                if (mem_raddr !== ea) begin
                    fails++;
                    $display("FAIL busy_start_addr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea);
                end
            end
            if (cyc == 8) begin
                tests++;
                if (vec_data !== exp_vec(b + 64'h40, 4) || vec_last !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_start_data last=%b got=%h exp=%h", vec_last, vec_data, exp_vec(b + 64'h40, 4));
                end
            end
            if (cyc == 1) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midjob;
        bit seen = 0;
        logic [2:0] e;
        vec_ready = 1'b0;
        start_job(64'h8000_0000, 32'd1, 5'd16, 64'd0);
        for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
            @(negedge clk);
            seen = vec_valid;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL midjob_hold got vec_valid=0 within 30 cycles exp=1");
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({mem_ren, mem_raddr, vec_valid, vec_data, vec_last, busy, done} !== '0) begin
            fails++;
            $display("FAIL midjob_reset got ren=%b addr=%h valid=%b last=%b busy=%b done=%b exp all 0",
                     mem_ren, mem_raddr, vec_valid, vec_last, busy, done);
        end
`ifdef OPFETCH_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL midjob_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        vec_ready = 1'b1;
        start_job(64'h8000_3000, 32'd1, 5'd2, 64'd0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            e = {cyc == 1, cyc == 3, cyc == 4};
            tests++;
            if ({mem_ren, vec_valid, done} !== e) begin
                fails++;
                $display("FAIL post_reset_ctl cyc=%0d got=%b exp=%b", cyc, {mem_ren, vec_valid, done}, e);
            end
            if (cyc == 1) begin
                tests++;
                if (mem_raddr !== 64'h8000_3000) begin
                    fails++;
                    $display("FAIL post_reset_addr got=%h exp=%h", mem_raddr, 64'h8000_3000);
                end
            end
            if (cyc == 3) begin
                tests++;
                if (vec_data !== exp_vec(64'h8000_3000, 2) || vec_last !== 1'b1) begin
                    fails++;
                    $display("FAIL post_reset_data last=%b got=%h exp=%h", vec_last, vec_data, exp_vec(64'h8000_3000, 2));
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [63:0] b = 64'hFFFF_FFFF_FFFF_FFC0;
        logic [2:0] e;
        vec_ready = 1'b1;
        start_job(b, 32'd2, 5'd2, 64'h40);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            e = {cyc == 1 || cyc == 4, cyc == 3 || cyc == 6, cyc == 7};
            tests++;
            if ({mem_ren, vec_valid, done} !== e) begin
                fails++;
                $display("FAIL wrap_ctl cyc=%0d got=%b exp=%b", cyc, {mem_ren, vec_valid, done}, e);
            end
            if (cyc == 4) begin
                tests++;
                if (mem_raddr !== 64'd0) begin
                    fails++;
                    $display("FAIL wrap_addr got=%h exp=0000000000000000", mem_raddr);
                end
            end
            if (cyc == 6) begin
                tests++;
                if (vec_data !== exp_vec(64'd0, 2) || vec_last !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_data last=%b got=%h exp=%h", vec_last, vec_data, exp_vec(64'd0, 2));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_misaligned;
        test_backpressure;
        test_empty;
        test_clamp;
        test_start_busy;
        test_reset_midjob;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
